// File: rtl/huc_bus_arbiter.sv
// Two-port arbiter and sequencer in front of the shared single-port memory.
// Fixed CPU priority with a starvation guard, address decode and per-region wait states.
module huc_bus_arbiter #(
  parameter int unsigned ROM_WAIT  = 0,
  parameter int unsigned RAM_WAIT  = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic        clk,
  input  logic        RESET_n,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [20:0] p0_addr,
  input  logic [20:0] p1_addr,
  input  logic [7:0]  p0_wdata,
  input  logic [7:0]  p1_wdata,
  output logic [7:0]  p0_rdata,
  output logic [7:0]  p1_rdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_re,
  output logic        mem_we,
  output logic        CE_n,
  output logic        CER_n,
  output logic        CE7_n
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StWait} state_e;
  typedef enum logic [1:0] {RgnRom, RgnRam, RgnIo, RgnOpen} region_e;

  function automatic region_e decode(input logic [20:0] a);
    if (a < 21'h100000) begin
      return RgnRom;
    end else if (a >= 21'h1F0000 && a <= 21'h1F7FFF) begin
      return RgnRam;
    end else if (a >= 21'h1FE000) begin
      return RgnIo;
    end
    return RgnOpen;
  endfunction

  function automatic logic [3:0] region_wait(input region_e r);
    case (r)
      RgnRom:  return 4'(ROM_WAIT);
      RgnRam:  return 4'(RAM_WAIT);
      RgnIo:   return 4'(IO_WAIT);
      default: return 4'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  region_e     region_q, region_d;
  logic        owner_q, owner_d;
  logic        txn_we_q, txn_we_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;
  logic [7:0]  p0_rdata_q, p0_rdata_d;
  logic [7:0]  p1_rdata_q, p1_rdata_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        ce_n_q, ce_n_d;
  logic        cer_n_q, cer_n_d;
  logic        ce7_n_q, ce7_n_d;

  logic        grant_p0, grant_p1;
  logic [20:0] sel_addr;
  region_e     sel_region;
  logic [7:0]  rd_byte;

  // Port 1 is forced through once it has lost MAX_STALL arbitrations in a row.
  always_comb begin
    grant_p0   = p0_req && !(p1_req && (stall_cnt_q == 4'(MAX_STALL)));
    grant_p1   = p1_req && !grant_p0;
    sel_addr   = grant_p1 ? p1_addr : p0_addr;
    sel_region = decode(sel_addr);
    rd_byte    = (region_q == RgnOpen) ? 8'hFF : mem_dout;
  end

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    owner_d     = owner_q;
    txn_we_d    = txn_we_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = stall_cnt_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    ce_n_d      = 1'b1;
    cer_n_d     = 1'b1;
    ce7_n_d     = 1'b1;

    case (state_q)
      StIdle: begin
        if (grant_p0 || grant_p1) begin
          owner_d  = grant_p1;
          txn_we_d = grant_p1 ? p1_we : p0_we;
          addr_d   = sel_addr;
          din_d    = grant_p1 ? p1_wdata : p0_wdata;
          region_d = sel_region;
          wcnt_d   = region_wait(sel_region);
          state_d  = StIssue;
          // Strobes/selects are registered here so they are clean for the whole ISSUE cycle.
          if (sel_region != RgnOpen) begin
            mem_re_d = !txn_we_d;
            mem_we_d = txn_we_d;
          end
          ce_n_d  = (sel_region != RgnRom);
          cer_n_d = (sel_region != RgnRam);
          ce7_n_d = (sel_region != RgnIo);
          if (grant_p1) begin
            stall_cnt_d = 4'd0;
          end else if (p1_req && (stall_cnt_q < 4'(MAX_STALL))) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
          end
        end
      end
      StIssue: begin
        state_d = StCapt;
      end
      StCapt: begin
        if (!txn_we_q) begin
          if (owner_q) begin
            p1_rdata_d = rd_byte;
          end else begin
            p0_rdata_d = rd_byte;
          end
        end
        if (wcnt_q == 4'd0) begin
          p0_ack_d = !owner_q;
          p1_ack_d = owner_q;
          state_d  = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          wcnt_d   = 4'd0;
          p0_ack_d = !owner_q;
          p1_ack_d = owner_q;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= StIdle;
      region_q    <= RgnOpen;
      owner_q     <= 1'b0;
      txn_we_q    <= 1'b0;
      addr_q      <= 21'd0;
      din_q       <= 8'd0;
      wcnt_q      <= 4'd0;
      stall_cnt_q <= 4'd0;
      p0_rdata_q  <= 8'd0;
      p1_rdata_q  <= 8'd0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      ce_n_q      <= 1'b1;
      cer_n_q     <= 1'b1;
      ce7_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      owner_q     <= owner_d;
      txn_we_q    <= txn_we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      ce_n_q      <= ce_n_d;
      cer_n_q     <= cer_n_d;
      ce7_n_q     <= ce7_n_d;
    end
  end

  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign CE_n     = ce_n_q;
  assign CER_n    = cer_n_q;
  assign CE7_n    = ce7_n_q;

endmodule
